// File: rtl/axi_stream_if.sv
// -----------------------------------------------------------------------------
// axi_stream_if
//   Minimal AXI-stream bundle used on the configuration bitstream path.
//
//   Parameters:
//     DATA_WIDTH : width of tdata in bits
//
//   Signals:
//     tvalid : source has a beat on tdata/tlast
//     tready : sink accepts the beat this cycle
//     tdata  : beat payload
//     tlast  : marks the final beat of a transfer
//
//   Modports:
//     master : drives tvalid/tdata/tlast, receives tready
//     slave  : receives tvalid/tdata/tlast, drives tready
// -----------------------------------------------------------------------------
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/bitstream_writer.sv
// -----------------------------------------------------------------------------
// bitstream_writer
//   Captures a parallel configuration word on a start pulse and serialises it
//   onto an AXI-stream master, one DATA_WIDTH beat per handshake, with tlast
//   on the final beat and a one-cycle done pulse afterwards.
//
//   Parameters:
//     NUM_BITS_TO_WRITE : payload length in bits (>= 1)
//     DATA_WIDTH        : bits per beat, equal to the interface tdata width
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : synchronous active-low reset
//     start     : single-cycle request, honoured only while ready = 1
//     bits      : payload, captured in the cycle start is accepted
//     ready     : idle and able to accept start
//     done      : one-cycle pulse after the final beat handshakes
//     bitstream : axi_stream_if.master (tvalid/tdata/tlast out, tready in)
//
//   Build option:
//     BITSTREAM_WRITER_MSB_FIRST_EN : when defined, beat 0 carries the
//     highest-order DATA_WIDTH bits of the zero-extended payload; otherwise
//     the payload is sent LSB-first.
// -----------------------------------------------------------------------------
module bitstream_writer #(
    parameter int NUM_BITS_TO_WRITE = 16,
    parameter int DATA_WIDTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_BITS_TO_WRITE-1:0] bits,
    output logic                         ready,
    output logic                         done,
    axi_stream_if.master                 bitstream
);
    localparam int NUM_BEATS = (NUM_BITS_TO_WRITE + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int SR_W      = NUM_BEATS * DATA_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        STATE__IDLE = 2'd0,
        STATE__SEND = 2'd1,
        STATE__DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [SR_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   beat_cnt_reg;

    logic [SR_W-1:0]       bits_ext;
    logic [SR_W-1:0]       shift_next;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  is_last;
    logic                  handshake;

    // Padding zeros sit above the payload in both orderings; only the
    // direction the word is consumed from differs.
    assign bits_ext = SR_W'(bits);

`ifdef BITSTREAM_WRITER_MSB_FIRST_EN
    assign beat_data  = shift_reg[SR_W-1 -: DATA_WIDTH];
    assign shift_next = shift_reg << DATA_WIDTH;
`else
    assign beat_data  = shift_reg[DATA_WIDTH-1:0];
    assign shift_next = shift_reg >> DATA_WIDTH;
`endif

    assign is_last   = (beat_cnt_reg == LAST_BEAT);
    assign handshake = (state_reg == STATE__SEND) && bitstream.tready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= STATE__IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE__IDLE: if (start)               state_next = STATE__SEND;
            STATE__SEND: if (handshake && is_last) state_next = STATE__DONE;
            STATE__DONE:                          state_next = STATE__IDLE;
            default:                              state_next = STATE__IDLE;
        endcase
    end

    // Payload shift register and beat counter. Only loaded from IDLE, so a
    // start or a change on bits during a transfer cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            beat_cnt_reg <= '0;
        end else if (state_reg == STATE__IDLE && start) begin
            shift_reg    <= bits_ext;
            beat_cnt_reg <= '0;
        end else if (handshake && !is_last) begin
            shift_reg    <= shift_next;
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
    end

    // Outputs decoded from state and registers only; tvalid never looks at
    // tready, and tdata/tlast hold until the handshake moves the register.
    always_comb begin
        ready            = 1'b0;
        done             = 1'b0;
        bitstream.tvalid = 1'b0;
        bitstream.tlast  = 1'b0;
        bitstream.tdata  = '0;
        case (state_reg)
            STATE__IDLE: ready = 1'b1;
            STATE__SEND: begin
                bitstream.tvalid = 1'b1;
                bitstream.tlast  = is_last;
                bitstream.tdata  = beat_data;
            end
            STATE__DONE: done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/bitstream_writer.md
# bitstream_writer

Transmit side of the configuration bitstream path. Captures a parallel configuration word on a `start` pulse and serialises it onto an AXI-stream master interface, ending with `tlast`. The receiving tile's bitstream reader, for example a LUT truth-table loader, can then consume it. Test benches and the top-level configuration sequencer use it to drive the fabric's `cfg_bitstream` chain.

## Interface

Parameters:
- `NUM_BITS_TO_WRITE`, default 16: payload length in bits; must be ≥ 1.
- `DATA_WIDTH`, default 8: bits per beat; must equal the `tdata` width of the connected `axi_stream_if`.
- `NUM_BEATS`, derived as ceil(`NUM_BITS_TO_WRITE` / `DATA_WIDTH`); not overridable.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only while `ready` = 1.
- `bits`  in  `NUM_BITS_TO_WRITE`  payload; sampled in the cycle `start` is accepted.
- `ready`  out  1  high when idle and able to accept `start`.
- `done`  out  1  one-cycle pulse after the final beat handshakes.
- `bitstream`  `axi_stream_if.master`  —  `tvalid`, `tdata[DATA_WIDTH-1:0]` and `tlast` are outputs; `tready` is an input.

## Operation

- State machine: `STATE__IDLE`, `STATE__SEND`, `STATE__DONE`.
- IDLE → SEND:
  - Condition: `start` = 1.
  - Capture `bits` into a shift register zero-extended to `NUM_BEATS*DATA_WIDTH`.
  - Clear the beat counter.
  - `ready` = 1 only in IDLE.
- SEND:
  - `tvalid` = 1.
  - `tdata` = the current low `DATA_WIDTH` bits of the shift register (LSB-first by default).
  - `tlast` = 1 only when beat counter == `NUM_BEATS`-1.
- SEND, on `tvalid && tready`:
  - If the beat is not the last, shift right by `DATA_WIDTH` and increment the counter; stay in SEND.
  - If it is the last, go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
- AXI rules:
  - Once `tvalid` rises it stays high, with `tdata`/`tlast` stable, until the handshake.
  - `tvalid` never depends combinationally on `tready`.
  - All outputs come from registers or state decode.
- Padding: bits of the final beat beyond `NUM_BITS_TO_WRITE` are 0.
- `start` while not `ready`: ignored, no side effects.
- `bits` changes after capture: no effect on the transfer in progress.
- Counter width: $clog2(`NUM_BEATS`) bits, minimum 1. `NUM_BEATS` = 1 gives `tlast` on the single beat.
- Outside SEND: `tvalid` = 0, `tlast` = 0, `tdata` = 0.

## Timing

- Reset values: state = IDLE, `ready` = 1, `done` = 0, `tvalid` = 0, `tlast` = 0, `tdata` = 0, counter = 0.
- Start latency: `start` accepted at edge N gives `tvalid` = 1 from cycle N+1.
- Throughput: with `tready` held high, one beat per cycle, so the transfer occupies `NUM_BEATS` consecutive cycles.
- Completion: last handshake at edge M gives `done` = 1 during cycle M+1 and `ready` = 1 from cycle M+2.
- Back-to-back transfers: minimum `NUM_BEATS`+2 cycles apart, start to start.
- Reset mid-transfer: all outputs return to their reset values at the next edge with `rst_n` = 0. The partial stream is abandoned with no `tlast`; the receiver must also be reset.

## Configuration

- `BITSTREAM_WRITER_MSB_FIRST_EN`:
  - Defined: beat 0 carries the highest-order `DATA_WIDTH` bits of the zero-extended payload. The shift register shifts left, `tdata` is taken from the top `DATA_WIDTH` bits, and padding zeros are placed above bit `NUM_BITS_TO_WRITE`-1, so they arrive first.
  - Undefined (default): LSB-first as described above, matching the fabric's bitstream readers.

## Test plan

- Basic transfer:
  - Stimulus: `NUM_BITS_TO_WRITE`=16, `DATA_WIDTH`=8, `bits`=16'hA55A, `tready`=1.
  - Required response: beats 8'h5A (`tlast`=0) then 8'hA5 (`tlast`=1). `done` pulses 1 cycle after the second beat, and `ready` returns 1 cycle later.
- Zero padding:
  - Stimulus: `NUM_BITS_TO_WRITE`=10, `bits`=10'h3FF.
  - Required response: beats 8'hFF, then 8'h03 with `tlast`=1.
  - With `BITSTREAM_WRITER_MSB_FIRST_EN`: beats 8'h03, then 8'hFF.
- Backpressure:
  - Stimulus: deassert `tready` for 3 cycles while beat 0 = 8'h5A is presented.
  - Required response: `tvalid` stays 1 and `tdata`=8'h5A is stable for all 3 cycles; beat 1 follows the cycle after `tready` rises.
- Ignored start:
  - Stimulus: pulse `start` with `bits`=16'hFFFF during an ongoing 16'hA55A transfer.
  - Required response: stream still 8'h5A, 8'hA5; exactly one `done`.
- Reset mid-transfer:
  - Stimulus: `rst_n`=0 after beat 0 handshakes.
  - Required response: next cycle `tvalid`=0, `tlast`=0, `ready`=1, no `done`. A new start then sends both beats from beat 0.
- Loopback:
  - Stimulus: drive a LUT with `WIDTH`=2 through this writer (`NUM_BITS_TO_WRITE`=4, `bits`=4'b1000).
  - Required response: after configure and run, `run_out`=1 only for `run_in`=2'b11.
